regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 133 +++++++++++++
 tb/tb_regfile_sb.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: NREG x XLEN register file with a per-register scoreboard and a
// bulk scrub engine.
//
// Index 0 is hardwired to zero. A write and a read of the same index in one
// cycle are bypassed combinationally, so the reader sees the new value and the
// busy flag drops in that same cycle. A clr_req in IDLE starts a scrub: the
// scoreboard is cleared at once, and then registers 1..NREG-1 are zeroed one
// per cycle. ready is low for the whole scrub.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset, overrides everything
//   rs1_idx, rs2_idx    read indices
//   rs1_data, rs2_data  combinational read data (with write bypass)
//   rs1_busy, rs2_busy  scoreboard pending-write flag for each read index
//   wr_en/wr_idx/wr_data  writeback port; the write also releases the reservation
//   rsv_en/rsv_idx      reserve a destination register at issue
//   clr_req             request a bulk scrub of all registers
//   ready               high while the scrub FSM is idle
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(NREG)-1:0]     rs1_idx,
    input  logic [$clog2(NREG)-1:0]     rs2_idx,
    output logic [XLEN-1:0]             rs1_data,
    output logic [XLEN-1:0]             rs2_data,
    output logic                        rs1_busy,
    output logic                        rs2_busy,
    input  logic                        wr_en,
    input  logic [$clog2(NREG)-1:0]     wr_idx,
    input  logic [XLEN-1:0]             wr_data,
    input  logic                        rsv_en,
    input  logic [$clog2(NREG)-1:0]     rsv_idx,
    input  logic                        clr_req,
    output logic                        ready
);

    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } state_t;

    state_t              state;
    logic [AW-1:0]       scrubCnt;
    logic [XLEN-1:0]     regs [NREG];
    logic [NREG-1:0]     sb;
    logic [NREG-1:0]     sbNext;
    logic                inIdle;
    logic                byp1;
    logic                byp2;

    assign inIdle = (state == IDLE);
    assign ready  = inIdle;

    // Release on writeback first, then reserve, so a producer issued in the
    // same cycle as the old producer's writeback keeps the register busy.
    always_comb begin
        sbNext = sb;
        if (wr_en) begin
            sbNext[wr_idx] = 1'b0;
        end
        if (rsv_en && (rsv_idx != '0)) begin
            sbNext[rsv_idx] = 1'b1;
        end
        sbNext[0] = 1'b0;
    end

    // Bypass only applies when the write will actually be accepted (IDLE).
    assign byp1 = inIdle && wr_en && (wr_idx == rs1_idx) && (rs1_idx != '0);
    assign byp2 = inIdle && wr_en && (wr_idx == rs2_idx) && (rs2_idx != '0);

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_idx != '0) begin
            rs1_data = byp1 ? wr_data : regs[rs1_idx];
        end
        if (rs2_idx != '0) begin
            rs2_data = byp2 ? wr_data : regs[rs2_idx];
        end
    end

    // sb[0] is never set, so index 0 reads as not busy without a special case.
    assign rs1_busy = inIdle && sb[rs1_idx] && !(wr_en && (wr_idx == rs1_idx));
    assign rs2_busy = inIdle && sb[rs2_idx] && !(wr_en && (wr_idx == rs2_idx));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            scrubCnt <= '0;
            sb       <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en && (wr_idx != '0)) begin
                        regs[wr_idx] <= wr_data;
                    end
                    // A same-cycle write is still taken; the scrub zeroes it later.
                    if (clr_req) begin
                        state    <= SCRUB;
                        scrubCnt <= AW'(1);
                        sb       <= '0;
                    end else begin
                        sb <= sbNext;
                    end
                end
                SCRUB: begin
                    regs[scrubCnt] <= '0;
                    // Stop on the last index rather than wrapping back to 0.
                    if (scrubCnt == LAST_IDX) begin
                        state    <= IDLE;
                        scrubCnt <= '0;
                    end else begin
                        scrubCnt <= scrubCnt + AW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int XA = 32;
    localparam int NA = 32;
    localparam int AA = 5;
    localparam int XB = 64;
    localparam int NB = 16;
    localparam int AB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instance A: default 32 x 32
    logic          rst;
    logic [AA-1:0] rs1_idx, rs2_idx, wr_idx, rsv_idx;
    logic [XA-1:0] rs1_data, rs2_data, wr_data;
    logic          rs1_busy, rs2_busy, wr_en, rsv_en, clr_req, ready;

    regfile_sb #(.XLEN(XA), .NREG(NA)) dutA (
        .clk(clk), .rst(rst),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_idx(rsv_idx),
        .clr_req(clr_req), .ready(ready)
    );

    // Instance B: 64-bit data, 16 registers
    logic          rstB;
    logic [AB-1:0] rs1IdxB, rs2IdxB, wrIdxB, rsvIdxB;
    logic [XB-1:0] rs1DataB, rs2DataB, wrDataB;
    logic          rs1BusyB, rs2BusyB, wrEnB, rsvEnB, clrReqB, readyB;

    regfile_sb #(.XLEN(XB), .NREG(NB)) dutB (
        .clk(clk), .rst(rstB),
        .rs1_idx(rs1IdxB), .rs2_idx(rs2IdxB),
        .rs1_data(rs1DataB), .rs2_data(rs2DataB),
        .rs1_busy(rs1BusyB), .rs2_busy(rs2BusyB),
        .wr_en(wrEnB), .wr_idx(wrIdxB), .wr_data(wrDataB),
        .rsv_en(rsvEnB), .rsv_idx(rsvIdxB),
        .clr_req(clrReqB), .ready(readyB)
    );

    // Reference model for instance A: architectural contents, pending flags,
    // and how many scrub cycles remain (0 means idle).
    logic [XA-1:0] mReg [NA];
    bit            mSb  [NA];
    int            mScrubLeft = 0;
    int            mScrubPos  = 0;

    function automatic logic [XA-1:0] expData(input logic [AA-1:0] idx);
        if (idx == 0) return '0;
        if (mScrubLeft == 0 && wr_en && wr_idx == idx) return wr_data;
        return mReg[idx];
    endfunction

    function automatic logic expBusy(input logic [AA-1:0] idx);
        if (idx == 0 || mScrubLeft > 0) return 1'b0;
        if (wr_en && wr_idx == idx) return 1'b0;
        return mSb[idx];
    endfunction

    function automatic logic expReady();
        return (mScrubLeft == 0);
    endfunction

    task automatic modelEdge();
        if (rst) begin
            for (int i = 0; i < NA; i++) begin mReg[i] = '0; mSb[i] = 0; end
            mScrubLeft = 0;
            mScrubPos  = 0;
        end else if (mScrubLeft == 0) begin
            if (wr_en && wr_idx != 0) mReg[wr_idx] = wr_data;
            if (wr_en) mSb[wr_idx] = 0;
            if (rsv_en && rsv_idx != 0) mSb[rsv_idx] = 1;
            if (clr_req) begin
                for (int i = 0; i < NA; i++) mSb[i] = 0;
                mScrubLeft = NA - 1;
                mScrubPos  = 1;
            end
        end else begin
            mReg[mScrubPos] = '0;
            mScrubPos++;
            mScrubLeft--;
        end
    endtask

    // Advance one clock: update the model from the inputs seen at the edge,
    // then give the DUT outputs time to settle.
    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic idleInputs();
        rst = 0; wr_en = 0; wr_idx = '0; wr_data = '0;
        rsv_en = 0; rsv_idx = '0; clr_req = 0;
    endtask

    task automatic test_reset();
        idleInputs();
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            rs1_idx = AA'($urandom_range(0, NA - 1));
            rs2_idx = AA'($urandom_range(0, NA - 1));
            #1;
            checks++;
            if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready actual=%b expected=1", ready); end
            checks++;
            if (rs1_data !== '0 || rs2_data !== '0) begin
                failures++; $display("FAIL reset_data actual=%h/%h expected=0", rs1_data, rs2_data);
            end
            checks++;
            if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
                failures++; $display("FAIL reset_busy actual=%b/%b expected=0", rs1_busy, rs2_busy);
            end
        end
    endtask

    task automatic test_write_read();
        idleInputs();
        wr_en = 1; wr_idx = 5; wr_data = 32'hDEADBEEF; rs1_idx = 5; rs2_idx = 6;
        #1;
        checks++;
        if (rs1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_x5 actual=%h expected=deadbeef", rs1_data); end
        checks++;
        if (rs2_data !== expData(6)) begin failures++; $display("FAIL bypass_other actual=%h expected=%h", rs2_data, expData(6)); end
        tick();
        wr_en = 0;
        #1;
        checks++;
        if (rs1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL read_x5 actual=%h expected=deadbeef", rs1_data); end
    endtask

    task automatic test_zero();
        idleInputs();
        wr_en = 1; wr_idx = 0; wr_data = 32'h1234; rsv_en = 1; rsv_idx = 0; rs1_idx = 0;
        #1;
        checks++;
        if (rs1_data !== '0) begin failures++; $display("FAIL x0_bypass actual=%h expected=0", rs1_data); end
        tick();
        idleInputs();
        #1;
        checks++;
        if (rs1_data !== '0 || rs1_busy !== 1'b0) begin
            failures++; $display("FAIL x0_read actual=%h busy=%b expected=0 busy=0", rs1_data, rs1_busy);
        end
    endtask

    task automatic test_scoreboard();
        idleInputs();
        rs2_idx = 7;
        rsv_en = 1; rsv_idx = 7;
        tick();
        rsv_en = 0;
        #1;
        checks++;
        if (rs2_busy !== 1'b1) begin failures++; $display("FAIL rsv_busy actual=%b expected=1", rs2_busy); end
        wr_en = 1; wr_idx = 7; wr_data = 32'h0BADF00D;
        #1;
        checks++;
        if (rs2_busy !== 1'b0 || rs2_data !== 32'h0BADF00D) begin
            failures++; $display("FAIL wb_cycle actual=busy %b data %h expected=busy 0 data 0badf00d", rs2_busy, rs2_data);
        end
        tick();
        wr_en = 0;
        #1;
        checks++;
        if (rs2_busy !== 1'b0) begin failures++; $display("FAIL wb_after actual=%b expected=0", rs2_busy); end
        rsv_en = 1; rsv_idx = 7; wr_en = 1; wr_idx = 7; wr_data = 32'h77;
        tick();
        idleInputs();
        #1;
        checks++;
        if (rs2_busy !== 1'b1 || rs2_data !== 32'h77) begin
            failures++; $display("FAIL rsv_wr_same actual=busy %b data %h expected=busy 1 data 77", rs2_busy, rs2_data);
        end
    endtask

    task automatic test_random();
        idleInputs();
        for (int c = 0; c < 300; c++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_idx  = AA'($urandom_range(0, NA - 1));
            wr_data = $urandom;
            rsv_en  = ($urandom_range(0, 2) == 0);
            rsv_idx = ($urandom_range(0, 1) == 1) ? wr_idx : AA'($urandom_range(0, NA - 1));
            clr_req = ($urandom_range(0, 99) == 0);
            rs1_idx = ($urandom_range(0, 2) == 0) ? wr_idx : AA'($urandom_range(0, NA - 1));
            rs2_idx = ($urandom_range(0, 3) == 0) ? rsv_idx : AA'($urandom_range(0, NA - 1));
            #1;
            checks++;
            if (rs1_data !== expData(rs1_idx) || rs2_data !== expData(rs2_idx)) begin
                failures++;
                $display("FAIL rand_data cyc=%0d actual=%h/%h expected=%h/%h", c, rs1_data, rs2_data,
                         expData(rs1_idx), expData(rs2_idx));
            end
            checks++;
            if (rs1_busy !== expBusy(rs1_idx) || rs2_busy !== expBusy(rs2_idx) || ready !== expReady()) begin
                failures++;
                $display("FAIL rand_ctl cyc=%0d actual=%b%b%b expected=%b%b%b", c, rs1_busy, rs2_busy, ready,
                         expBusy(rs1_idx), expBusy(rs2_idx), expReady());
            end
            tick();
        end
        // Drain any scrub started at random.
        idleInputs();
        for (int c = 0; c < 40 && mScrubLeft > 0; c++) tick();
    endtask

    task automatic fillAll();
        idleInputs();
        for (int i = 1; i < NA; i++) begin
            wr_en = 1; wr_idx = AA'(i); wr_data = $urandom | 32'h1;
            rsv_en = 1; rsv_idx = AA'(NA - i);
            tick();
        end
        idleInputs();
    endtask

    task automatic test_scrub();
        int lowCycles;
        fillAll();
        clr_req = 1;
        wr_en = 1; wr_idx = 3; wr_data = 32'hA5A5A5A5;
        tick();
        lowCycles = 0;
        while (ready === 1'b0 && lowCycles < 100) begin
            // Traffic that must be ignored during the scrub.
            wr_en   = 1; wr_idx = AA'($urandom_range(1, NA - 1)); wr_data = $urandom | 32'h1;
            rsv_en  = 1; rsv_idx = AA'($urandom_range(1, NA - 1));
            clr_req = ($urandom_range(0, 1) == 1);
            rs1_idx = wr_idx;
            rs2_idx = AA'($urandom_range(0, NA - 1));
            #1;
            checks++;
            if (rs1_data !== expData(rs1_idx) || rs2_data !== expData(rs2_idx)
                || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
                failures++;
                $display("FAIL scrub_read cyc=%0d actual=%h/%h busy %b%b expected=%h/%h busy 00", lowCycles,
                         rs1_data, rs2_data, rs1_busy, rs2_busy, expData(rs1_idx), expData(rs2_idx));
            end
            tick();
            lowCycles++;
        end
        idleInputs();
        #1;
        checks++;
        if (lowCycles !== NA - 1) begin failures++; $display("FAIL scrub_len actual=%0d expected=%0d", lowCycles, NA - 1); end
        for (int i = 0; i < NA; i++) begin
            rs1_idx = AA'(i); rs2_idx = AA'(NA - 1 - i);
            #1;
            checks++;
            if (rs1_data !== '0 || rs2_data !== '0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
                failures++;
                $display("FAIL scrub_after idx=%0d actual=%h/%h busy %b%b expected=0/0 busy 00", i,
                         rs1_data, rs2_data, rs1_busy, rs2_busy);
            end
        end
    endtask

    task automatic test_reset_mid_scrub();
        fillAll();
        clr_req = 1;
        tick();
        clr_req = 0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks++;
        if (ready !== 1'b1) begin failures++; $display("FAIL midrst_ready actual=%b expected=1", ready); end
        for (int i = 0; i < NA; i++) begin
            rs1_idx = AA'(i); rs2_idx = AA'(i);
            #1;
            checks++;
            if (rs1_data !== '0 || rs2_data !== '0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
                failures++;
                $display("FAIL midrst_state idx=%0d actual=%h busy %b%b expected=0 busy 00", i, rs1_data, rs1_busy, rs2_busy);
            end
        end
    endtask

    task automatic test_wide();
        int lowCycles;
        rstB = 1; wrEnB = 0; wrIdxB = '0; wrDataB = '0; rsvEnB = 0; rsvIdxB = '0; clrReqB = 0;
        rs1IdxB = 15; rs2IdxB = 14;
        @(posedge clk); #1;
        rstB = 0;
        wrEnB = 1; wrIdxB = 15; wrDataB = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        wrEnB = 1; wrIdxB = 14; wrDataB = 64'h0123_4567_89AB_CDEF;
        @(posedge clk); #1;
        wrEnB = 0;
        #1;
        checks++;
        if (rs1DataB !== 64'hFFFF_FFFF_FFFF_FFFF || rs2DataB !== 64'h0123_4567_89AB_CDEF) begin
            failures++; $display("FAIL wide_read actual=%h/%h expected=ffffffffffffffff/0123456789abcdef", rs1DataB, rs2DataB);
        end
        clrReqB = 1;
        @(posedge clk); #1;
        clrReqB = 0;
        lowCycles = 0;
        while (readyB === 1'b0 && lowCycles < 100) begin
            @(posedge clk); #1;
            lowCycles++;
        end
        checks++;
        if (lowCycles !== NB - 1) begin failures++; $display("FAIL wide_scrub_len actual=%0d expected=%0d", lowCycles, NB - 1); end
        checks++;
        if (rs1DataB !== '0 || rs2DataB !== '0) begin
            failures++; $display("FAIL wide_scrub_data actual=%h/%h expected=0", rs1DataB, rs2DataB);
        end
    endtask

    initial begin
        idleInputs();
        rst = 1; rs1_idx = '0; rs2_idx = '0;
        rstB = 1; wrEnB = 0; wrIdxB = '0; wrDataB = '0; rsvEnB = 0; rsvIdxB = '0; clrReqB = 0;
        rs1IdxB = '0; rs2IdxB = '0;
        test_reset();
        test_write_read();
        test_zero();
        test_scoreboard();
        test_random();
        test_scrub();
        test_reset_mid_scrub();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
